// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares the single SDRAM controller user port among three requesters
//   (0 = boot loader/DMA, 1 = data load/store, 2 = instruction fetch).
//   Requests are held off until calibration completes. Then one access is
//   issued and its busy pulse is awaited. The access is then completed with a
//   one-cycle ack, and load data is returned in the ack cycle.
// Ports
//   clk, rst_x              clock, asynchronous active-low reset
//   i_req/i_we              per-port request (level) and store flag
//   i_addr/i_wdata/i_ctrl   per-port address, store data, {unsigned,size}
//   o_ack/o_rdata           one-hot completion pulse, load data
//   o_gnt/o_err             current owner, sticky watchdog timeout
//   o_rd_en/o_wr_en/o_addr/o_data/o_ctrl   controller command side
//   i_busy/i_mdata/i_calib  controller status, read data, calibration done
module dram_port_arbiter #(
  parameter int RR_EN = 1,
  parameter int TMO_W = 8
) (
  input  logic        clk,
  input  logic        rst_x,
  input  logic [2:0]  i_req,
  input  logic [2:0]  i_we,
  input  logic [95:0] i_addr,
  input  logic [95:0] i_wdata,
  input  logic [8:0]  i_ctrl,
  output logic [2:0]  o_ack,
  output logic [31:0] o_rdata,
  output logic [2:0]  o_gnt,
  output logic        o_err,
  output logic        o_rd_en,
  output logic        o_wr_en,
  output logic [31:0] o_addr,
  output logic [31:0] o_data,
  output logic [2:0]  o_ctrl,
  input  logic        i_busy,
  input  logic [31:0] i_mdata,
  input  logic        i_calib
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAITB, S_WAITD, S_DONE} state_e;

  // Last count value before the watchdog fires: the state is left after
  // 2**TMO_W-1 cycles without progress.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(2**TMO_W - 2);

  state_e            state_q, state_d;
  logic [2:0]        gnt_q, gnt_d;
  logic [2:0]        ack_q, ack_d;
  logic [1:0]        own_q, own_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic              we_q, we_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  // Winner selection, evaluated every cycle but only consumed in IDLE.
  logic       win_vld;
  logic [1:0] win_idx;

  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = 2'd0;
    j       = 0;
    for (int s = 1; s <= 3; s++) begin
      // Round-robin starts just after the last owner; fixed priority scans 0..2.
      if (RR_EN != 0) j = (int'(rr_ptr_q) + s) % 3;
      else            j = s - 1;
      if (!win_vld && i_req[j]) begin
        win_vld = 1'b1;
        win_idx = 2'(j);
      end
    end
  end

  always_comb begin
    // NOTE: every next-state signal takes its current value first, so no
    // branch can leave one unassigned and infer a latch.
    state_d  = state_q;
    gnt_d    = gnt_q;
    ack_d    = ack_q;
    own_d    = own_q;
    rr_ptr_d = rr_ptr_q;
    we_d     = we_q;
    rd_en_d  = rd_en_q;
    wr_en_d  = wr_en_q;
    addr_d   = addr_q;
    data_d   = data_q;
    ctrl_d   = ctrl_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    tmo_d    = tmo_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_calib && win_vld && !i_busy) begin
          own_d   = win_idx;
          gnt_d   = 3'b001 << win_idx;
          we_d    = i_we[win_idx];
          rd_en_d = !i_we[win_idx];
          wr_en_d = i_we[win_idx];
          addr_d  = i_addr[32*win_idx +: 32];
          data_d  = i_wdata[32*win_idx +: 32];
          ctrl_d  = i_ctrl[3*win_idx +: 3];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        rd_en_d = 1'b0;
        wr_en_d = 1'b0;
        tmo_d   = '0;
        state_d = S_WAITB;
      end
      S_WAITB: begin
        if (i_busy) begin
          tmo_d   = '0;
          state_d = S_WAITD;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          ack_d   = gnt_q;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAITD: begin
        if (!i_busy) begin
          if (!we_q) rdata_d = i_mdata;
          ack_d   = gnt_q;
          state_d = S_DONE;
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 1'b1;
          rdata_d = '0;
          ack_d   = gnt_q;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_DONE: begin
        ack_d = 3'b000;
        gnt_d = 3'b000;
        if (RR_EN != 0) rr_ptr_d = own_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q  <= S_IDLE;
      gnt_q    <= '0;
      ack_q    <= '0;
      own_q    <= '0;
      rr_ptr_q <= 2'd2;  // port 0 is searched first after reset
      we_q     <= 1'b0;
      rd_en_q  <= 1'b0;
      wr_en_q  <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      ctrl_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      own_q    <= own_d;
      rr_ptr_q <= rr_ptr_d;
      we_q     <= we_d;
      rd_en_q  <= rd_en_d;
      wr_en_q  <= wr_en_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      ctrl_q   <= ctrl_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
    end
  end

  assign o_ack   = ack_q;
  assign o_rdata = rdata_q;
  assign o_gnt   = gnt_q;
  assign o_err   = err_q;
  assign o_rd_en = rd_en_q;
  assign o_wr_en = wr_en_q;
  assign o_addr  = addr_q;
  assign o_data  = data_q;
  assign o_ctrl  = ctrl_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// tb_dram_port_arbiter
//   Directed bench: a round-robin instance (dut) and a fixed-priority
//   instance (dut_fp) share the requester stimulus. Each instance has its own
//   small controller model that raises busy the cycle after a strobe and
//   holds it for six cycles. That busy can be suppressed to exercise the
//   watchdog.
module tb_dram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic [2:0]  req, we;
  logic [95:0] addr, wdata;
  logic [8:0]  ctrl;
  logic [31:0] mdata;
  logic        calib;
  logic        bmode;  // 1: controller model answers with busy

  logic [2:0]  a_ack, a_gnt, a_ctrl, b_ack, b_gnt, b_ctrl;
  logic [31:0] a_rdata, a_addr, a_data, b_rdata, b_addr, b_data;
  logic        a_err, a_rd, a_wr, b_err, b_rd, b_wr;
  logic [3:0]  a_bcnt, b_bcnt;
  logic        a_busy, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dram_port_arbiter #(.RR_EN(1), .TMO_W(4)) dut (
    .clk(clk), .rst_x(rst_x), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_ctrl(ctrl), .o_ack(a_ack), .o_rdata(a_rdata),
    .o_gnt(a_gnt), .o_err(a_err), .o_rd_en(a_rd), .o_wr_en(a_wr),
    .o_addr(a_addr), .o_data(a_data), .o_ctrl(a_ctrl), .i_busy(a_busy),
    .i_mdata(mdata), .i_calib(calib)
  );

  dram_port_arbiter #(.RR_EN(0), .TMO_W(4)) dut_fp (
    .clk(clk), .rst_x(rst_x), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_ctrl(ctrl), .o_ack(b_ack), .o_rdata(b_rdata),
    .o_gnt(b_gnt), .o_err(b_err), .o_rd_en(b_rd), .o_wr_en(b_wr),
    .o_addr(b_addr), .o_data(b_data), .o_ctrl(b_ctrl), .i_busy(b_busy),
    .i_mdata(mdata), .i_calib(calib)
  );

  // Controller models: busy for six cycles, starting the cycle after a strobe.
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x)                       a_bcnt <= '0;
    else if (bmode && (a_rd || a_wr)) a_bcnt <= 4'd6;
    else if (a_bcnt != 0)             a_bcnt <= a_bcnt - 1'b1;
  end
  always @(posedge clk or negedge rst_x) begin
    if (!rst_x)                       b_bcnt <= '0;
    else if (bmode && (b_rd || b_wr)) b_bcnt <= 4'd6;
    else if (b_bcnt != 0)             b_bcnt <= b_bcnt - 1'b1;
  end
  assign a_busy = (a_bcnt != 0);
  assign b_busy = (b_bcnt != 0);

  // Grant log: one entry per issued strobe.
  logic       log_en = 1'b0;
  logic [2:0] a_log[$];
  logic [2:0] b_log[$];
  always @(negedge clk) begin
    if (log_en) begin
      if (a_rd || a_wr) a_log.push_back(a_gnt);
      if (b_rd || b_wr) b_log.push_back(b_gnt);
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic set_port(input int k, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [2:0] c);
    we[k]            = w;
    addr[32*k +: 32] = a;
    wdata[32*k +: 32] = d;
    ctrl[3*k +: 3]   = c;
  endtask

  // Returns at the falling edge of the strobe cycle of dut.
  task automatic wait_strobe(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (a_rd || a_wr) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_strobe_timeout"}, 32'd0, 32'd1);
  endtask

  // Returns at the falling edge of the ack cycle of dut; cyc = cycles waited.
  task automatic wait_ack(input string tag, output int cyc);
    bit ok = 1'b0;
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cyc++;
      if (a_ack != 3'b000) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_ack_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int cyc, bad, acks;
    logic [2:0] rr_exp [4];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    req = '0; we = '0; addr = '0; wdata = '0; ctrl = '0;
    mdata = '0; calib = 1'b0; bmode = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_gnt", 32'(a_gnt), 32'd0);
    check("rst_ack", 32'(a_ack), 32'd0);
    check("rst_strobes", {30'd0, a_rd, a_wr}, 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_rdata", a_rdata, 32'd0);
    rst_x = 1'b1;

    // Calibration holds off the request, then a single read strobe
    set_port(0, 1'b0, 32'h40, 32'h0, 3'd2);
    req = 3'b001;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_rd || a_wr || a_gnt != 3'b000) bad++;
    end
    check("calib_hold", 32'(bad), 32'd0);
    calib = 1'b1;
    wait_strobe("calib");
    check("calib_rd", 32'(a_rd), 32'd1);
    check("calib_gnt", 32'(a_gnt), 32'b001);
    @(negedge clk);
    check("calib_rd_width", 32'(a_rd), 32'd0);
    wait_ack("calib", cyc);
    check("calib_ack", 32'(a_ack), 32'b001);
    req = 3'b000;
    @(negedge clk);
    check("calib_ack_once", 32'(a_ack), 32'd0);

    // Load on port 1; calibration drops mid-access and must not stall it
    mdata = 32'hDEADBEEF;
    set_port(1, 1'b0, 32'h100, 32'h0, 3'd2);
    req = 3'b010;
    wait_strobe("ld");
    check("ld_rd", {30'd0, a_rd, a_wr}, 32'b10);
    check("ld_addr", a_addr, 32'h100);
    check("ld_ctrl", 32'(a_ctrl), 32'd2);
    check("ld_gnt", 32'(a_gnt), 32'b010);
    calib = 1'b0;
    wait_ack("ld", cyc);
    check("ld_ack", 32'(a_ack), 32'b010);
    check("ld_rdata", a_rdata, 32'hDEADBEEF);
    req = 3'b000;
    calib = 1'b1;
    @(negedge clk);
    check("ld_ack_once", 32'(a_ack), 32'd0);
    check("ld_gnt_clear", 32'(a_gnt), 32'd0);

    // Store on port 2: read data must stay untouched
    mdata = 32'h11111111;
    set_port(2, 1'b1, 32'h203, 32'hABCD, 3'd1);
    req = 3'b100;
    wait_strobe("st");
    check("st_wr", {30'd0, a_rd, a_wr}, 32'b01);
    check("st_addr", a_addr, 32'h203);
    check("st_data", a_data, 32'hABCD);
    check("st_ctrl", 32'(a_ctrl), 32'd1);
    @(negedge clk);
    check("st_wr_width", 32'(a_wr), 32'd0);
    wait_ack("st", cyc);
    check("st_ack", 32'(a_ack), 32'b100);
    check("st_rdata_kept", a_rdata, 32'hDEADBEEF);
    req = 3'b000;
    @(negedge clk);

    // All three ports request: round-robin vs fixed priority
    a_log.delete();
    b_log.delete();
    log_en = 1'b1;
    req = 3'b111;
    acks = 0;
    bad = 0;
    for (int i = 0; i < 300 && acks < 4; i++) begin
      @(negedge clk);
      if (a_ack != 3'b000) begin
        acks++;
        if (a_ack != a_gnt || !$onehot(a_ack)) bad++;
      end
    end
    req = 3'b000;
    log_en = 1'b0;
    check("rr_acks", 32'(acks), 32'd4);
    check("rr_ack_onehot", 32'(bad), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rr_order%0d", i),
            32'((i < a_log.size()) ? a_log[i] : 3'b000), 32'(rr_exp[i]));
      check($sformatf("fp_order%0d", i),
            32'((i < b_log.size()) ? b_log[i] : 3'b000), 32'b001);
    end
    repeat (2) @(negedge clk);

    // Watchdog: busy never rises, access ends after 15 wait cycles
    bmode = 1'b0;
    set_port(0, 1'b0, 32'h80, 32'h0, 3'd2);
    req = 3'b001;
    wait_strobe("tmo");
    wait_ack("tmo", cyc);
    check("tmo_latency", 32'(cyc), 32'd16);
    check("tmo_ack", 32'(a_ack), 32'b001);
    check("tmo_err", 32'(a_err), 32'd1);
    check("tmo_rdata", a_rdata, 32'd0);
    req = 3'b000;
    bmode = 1'b1;
    repeat (2) @(negedge clk);
    check("tmo_err_sticky", 32'(a_err), 32'd1);

    // Reset during WAITD: everything clears, pointer returns to port 0 first
    set_port(1, 1'b0, 32'h104, 32'h0, 3'd2);
    req = 3'b011;
    wait_strobe("arst");
    check("arst_pre_gnt", 32'(a_gnt), 32'b010);
    repeat (2) @(negedge clk);
    check("arst_in_waitd", 32'(a_busy), 32'd1);
    rst_x = 1'b0;
    #1;
    check("arst_gnt", 32'(a_gnt), 32'd0);
    check("arst_strobes", {30'd0, a_rd, a_wr}, 32'd0);
    check("arst_ack", 32'(a_ack), 32'd0);
    check("arst_err", 32'(a_err), 32'd0);
    check("arst_addr", a_addr, 32'd0);
    @(negedge clk);
    rst_x = 1'b1;
    wait_strobe("arst2");
    check("arst_regrant", 32'(a_gnt), 32'b001);
    wait_ack("arst2", cyc);
    check("arst_ack_port0", 32'(a_ack), 32'b001);
    req = 3'b000;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
